// File: rtl/vram_scanout_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_scanout_if
// Description : VRAM pixel-port and pixel-stream signals for vram_scanout.
//               master = scanout engine, slave = VRAM + display side.
// Revision    : 1.0  initial release
// ============================================================================
interface vram_scanout_if;
  logic        start;
  logic        busy;
  logic        p_read;
  logic [12:0] p_addr;
  logic [15:0] p_dout;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic        pix_sol;
  logic        pix_sof;
  logic        pix_eof;

  modport master (
    input  start, p_dout, pix_ready,
    output busy, p_read, p_addr, pix_valid, pix_data, pix_sol, pix_sof, pix_eof
  );

  modport slave (
    output start, p_dout, pix_ready,
    input  busy, p_read, p_addr, pix_valid, pix_data, pix_sol, pix_sof, pix_eof
  );
endinterface
`default_nettype wire

// File: rtl/vram_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vram_scanout
// Description : Demand-driven raster reader for the VRAM pixel port. Keeps at
//               most two words buffered or in flight and emits one pixel per
//               valid/ready handshake, LSB of each word first.
// Revision    : 1.0  initial release
// ============================================================================
module vram_scanout #(
  parameter int WORDS_PER_LINE = 32,
  parameter int LINES          = 256
) (
  input  wire logic      clk,
  input  wire logic      reset,
  vram_scanout_if.master bus
);
  localparam int c_WORDS    = WORDS_PER_LINE * LINES;
  localparam int c_PIXELS   = c_WORDS * 16;
  localparam int c_LINE_PIX = WORDS_PER_LINE * 16;
  localparam int c_PW       = $clog2(c_PIXELS);
  localparam int c_CW       = $clog2(c_LINE_PIX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [12:0]       fetch_q, fetch_d;   // next word address to issue
  logic [12:0]       addr_q,  addr_d;    // address of the last issued word
  logic              ph2_q,   ph2_d;     // a read is in its data cycle
  logic [1:0]        cnt_q,   cnt_d;     // buffered words
  logic [15:0]       w0_q,    w0_d;      // head word
  logic [15:0]       w1_q,    w1_d;
  logic [c_PW-1:0]   pix_q,   pix_d;     // pixel index within frame
  logic [c_CW-1:0]   col_q,   col_d;     // column within line

  logic w_issue, w_valid, w_accept, w_pop, w_push, w_last_pix, w_last_word, w_last_col;

  // Buffered plus in-flight words must stay below two before a new launch.
  assign w_issue     = (state_q == RUN) && ((cnt_q + {1'b0, ph2_q}) < 2'd2);
  assign w_valid     = (cnt_q != 2'd0);
  assign w_accept    = w_valid & bus.pix_ready;
  assign w_pop       = w_accept & (pix_q[3:0] == 4'hF);
  assign w_push      = ph2_q;
  assign w_last_pix  = (pix_q == c_PW'(c_PIXELS - 1));
  assign w_last_word = (fetch_q == 13'(c_WORDS - 1));
  assign w_last_col  = (col_q == c_CW'(c_LINE_PIX - 1));

  assign bus.busy      = (state_q != IDLE);
  assign bus.p_read    = w_issue | ph2_q;
  assign bus.p_addr    = w_issue ? fetch_q : addr_q;
  assign bus.pix_valid = w_valid;
  assign bus.pix_data  = w_valid & w0_q[pix_q[3:0]];
  assign bus.pix_sol   = w_valid & (col_q == '0);
  assign bus.pix_sof   = w_valid & (pix_q == '0);
  assign bus.pix_eof   = w_valid & w_last_pix;

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_q <= '0;
      addr_q  <= '0;
      ph2_q   <= 1'b0;
      cnt_q   <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      pix_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      ph2_q   <= ph2_d;
      cnt_q   <= cnt_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
    end
  end

  // Frame sequencing: run until the last word is issued, drain until eof is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (w_issue && w_last_word) state_d = DRAIN;
      DRAIN:   if (w_accept && w_last_pix) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch counters, prefetch buffer and pixel counters.
  always_comb begin
    fetch_d = fetch_q;
    addr_d  = addr_q;
    ph2_d   = w_issue;
    cnt_d   = cnt_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    pix_d   = pix_q;
    col_d   = col_q;

    if (w_issue) begin
      addr_d  = fetch_q;
      fetch_d = w_last_word ? 13'd0 : fetch_q + 13'd1;
    end

    case ({w_push, w_pop})
      2'b10: begin
        if (cnt_q == 2'd0) w0_d = bus.p_dout;
        else               w1_d = bus.p_dout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        w0_d  = w1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Word arriving while the head pops: it lands behind any remaining word.
        if (cnt_q == 2'd1) begin
          w0_d = bus.p_dout;
        end else begin
          w0_d = w1_q;
          w1_d = bus.p_dout;
        end
      end
      default: ;
    endcase

    if (w_accept) begin
      pix_d = w_last_pix ? '0 : pix_q + 1'b1;
      col_d = w_last_col ? '0 : col_q + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vram_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_scanout
// Description : Randomized bench for vram_scanout with a raster reference
//               model, VRAM model and read-protocol monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vram_scanout;
  localparam int c_WPL   = 4;
  localparam int c_LINES = 8;
  localparam int c_WORDS = c_WPL * c_LINES;
  localparam int c_PIX   = c_WORDS * 16;
  localparam int c_LPIX  = c_WPL * 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  vram_scanout_if vif ();

  vram_scanout #(.WORDS_PER_LINE(c_WPL), .LINES(c_LINES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.master)
  );

  always #5 clk = ~clk;

  // VRAM model: registered read port, output gated by p_read.
  logic [15:0] mem [0:8191];
  logic [15:0] rd_q;
  always @(posedge clk) rd_q <= mem[vif.p_addr];
  assign vif.p_dout = vif.p_read ? rd_q : 16'h0000;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int mode = 0;       // 0 ready low, 1 ready high, 2 random ready
  bit spam = 1'b0;    // random start pulses while busy

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      0:       vif.pix_ready = 1'b0;
      1:       vif.pix_ready = 1'b1;
      default: vif.pix_ready = 1'($urandom_range(0, 1));
    endcase
    if (spam) vif.start = vif.busy && ($urandom_range(0, 5) == 0);
  endtask

  task automatic fill(input bit ramp);
    for (int i = 0; i < c_WORDS; i++) mem[i] = ramp ? 16'(i) : 16'($urandom);
  endtask

  // ---------------- reference model / monitor ----------------
  int   exp_addr, exp_pix, occ, n_issue, sol_cnt, sof_cnt, bubbles;
  int   frames_done = 0;
  bit   prev_issue, streaming, hold_pend, eof_pend, rdy_all, is_issue;
  logic [12:0] prev_addr;
  logic [4:0]  held;
  logic [15:0] exp_w;
  logic [3:0]  expv;

  initial begin
    eof_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (eof_pend) begin
        check("busy_after_eof", 32'(vif.busy), 32'd0);
        eof_pend = 1'b0;
      end
      if (!vif.busy && !vif.p_read && !vif.pix_valid) begin
        exp_addr = 0; exp_pix = 0; occ = 0; n_issue = 0;
        sol_cnt = 0; sof_cnt = 0; bubbles = 0;
        prev_issue = 1'b0; prev_addr = '0; streaming = 1'b0;
        hold_pend = 1'b0; rdy_all = 1'b1;
      end else begin
        is_issue = vif.p_read && (!prev_issue || vif.p_addr != prev_addr);
        if (prev_issue) check("p_read_data_cycle", 32'(vif.p_read), 32'd1);
        if (is_issue) begin
          check("fetch_addr", 32'(vif.p_addr), 32'(exp_addr));
          check("fetch_room", 32'((occ + int'(prev_issue)) < 2), 32'd1);
          exp_addr++;
          n_issue++;
        end
        if (hold_pend) begin
          check("pix_hold", 32'({vif.pix_valid, vif.pix_data, vif.pix_sol, vif.pix_sof, vif.pix_eof}),
                32'(held));
          hold_pend = 1'b0;
        end
        check("pix_valid", 32'(vif.pix_valid), 32'(occ > 0));
        if (vif.pix_valid) begin
          exp_w = mem[exp_pix / 16];
          expv  = {exp_w[exp_pix % 16], (exp_pix % c_LPIX) == 0, exp_pix == 0, exp_pix == c_PIX - 1};
          check("pix", 32'({vif.pix_data, vif.pix_sol, vif.pix_sof, vif.pix_eof}), 32'(expv));
          if (vif.pix_ready) begin
            streaming = 1'b1;
            sol_cnt += int'(vif.pix_sol);
            sof_cnt += int'(vif.pix_sof);
            if (exp_pix % 16 == 15) occ--;
            if (vif.pix_eof) begin
              eof_pend = 1'b1;
              frames_done++;
              check("sol_count", 32'(sol_cnt), 32'(c_LINES));
              check("sof_count", 32'(sof_cnt), 32'd1);
              check("words_fetched", 32'(exp_addr), 32'(c_WORDS));
              if (rdy_all) check("bubbles", 32'(bubbles), 32'd0);
            end
            exp_pix++;
          end else begin
            hold_pend = 1'b1;
            held = {vif.pix_valid, vif.pix_data, vif.pix_sol, vif.pix_sof, vif.pix_eof};
          end
        end else if (streaming && exp_pix < c_PIX) begin
          bubbles++;
        end
        if (!vif.pix_ready) rdy_all = 1'b0;
        if (prev_issue) occ++;
        prev_issue = is_issue;
        prev_addr  = vif.p_addr;
      end
    end
  end

  task automatic wait_frame();
    int f0 = frames_done;
    int k  = 0;
    while (frames_done == f0 && k < 5000) begin
      tick();
      k++;
    end
    check("frame_timeout", 32'(frames_done != f0), 32'd1);
    tick();
    tick();
  endtask

  task automatic start_pulse();
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   k;
    vif.start = 1'b0;
    vif.pix_ready = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_outputs",
          32'({vif.busy, vif.p_read, vif.pix_valid, vif.pix_data, vif.pix_sol, vif.pix_sof, vif.pix_eof}),
          32'd0);
    check("reset_addr", 32'(vif.p_addr), 32'd0);

    // Start latency with VRAM[0]=1.
    fill(1'b0);
    mem[0] = 16'h0001;
    mode = 1;
    tick();
    start_pulse();
    check("c1_busy", 32'(vif.busy), 32'd1);
    check("c1_p_read", 32'(vif.p_read), 32'd1);
    check("c1_p_addr", 32'(vif.p_addr), 32'd0);
    tick();
    tick();
    check("c3_pix", 32'({vif.pix_valid, vif.pix_data, vif.pix_sof, vif.pix_sol}), 32'hF);
    wait_frame();

    // Backpressure: only two words fetched while ready is low.
    fill(1'b0);
    mode = 0;
    tick();
    start_pulse();
    repeat (12) tick();
    check("stall_issues", 32'(n_issue), 32'd2);
    check("stall_p_read", 32'(vif.p_read), 32'd0);
    check("stall_valid", 32'(vif.pix_valid), 32'd1);
    mode = 1;
    wait_frame();

    // Ramp image, ready held high.
    fill(1'b1);
    mode = 1;
    tick();
    start_pulse();
    wait_frame();

    // Random ready frames with ignored start pulses while busy.
    for (int f = 0; f < 2; f++) begin
      fill(1'b0);
      mode = 2;
      tick();
      start_pulse();
      spam = (f == 1);
      wait_frame();
      spam = 1'b0;
      vif.start = 1'b0;
    end

    // Start on the eof acceptance cycle is ignored; a later start restarts at 0.
    fill(1'b0);
    mode = 1;
    tick();
    start_pulse();
    k = 0;
    while (!(vif.pix_valid && vif.pix_eof) && k < 5000) begin
      tick();
      k++;
    end
    check("eof_reached", 32'(vif.pix_valid && vif.pix_eof), 32'd1);
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    check("eof_start_busy", 32'(vif.busy), 32'd0);
    check("eof_start_p_read", 32'(vif.p_read), 32'd0);
    tick();
    tick();
    fill(1'b0);
    start_pulse();
    check("restart_p_read", 32'(vif.p_read), 32'd1);
    check("restart_addr", 32'(vif.p_addr), 32'd0);
    wait_frame();

    // Reset mid-stream aborts the frame.
    fill(1'b0);
    mode = 2;
    tick();
    start_pulse();
    repeat (100) tick();
    reset = 1'b1;
    #1;
    check("midreset_outputs",
          32'({vif.busy, vif.p_read, vif.pix_valid, vif.pix_data, vif.pix_sol, vif.pix_sof, vif.pix_eof}),
          32'd0);
    tick();
    tick();
    reset = 1'b0;
    acc = 1'b0;
    repeat (10) begin
      tick();
      acc = acc | vif.p_read | vif.busy | vif.pix_valid;
    end
    check("after_reset_quiet", 32'(acc), 32'd0);

    // Fresh frame after the abort.
    start_pulse();
    check("post_reset_addr", 32'(vif.p_addr), 32'd0);
    wait_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
